// File: rtl/bcd_seq_conv.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seq_conv
// Description : Iterative shift-add-3 (double-dabble) binary-to-BCD converter.
//               Converts an IN_WIDTH-bit binary value into DIGITS packed BCD
//               digits over IN_WIDTH clock cycles. The output register only
//               updates on completion, so downstream logic never sees a
//               partially converted value.
// Ports       : clk       - system clock
//               rst       - synchronous, active-high reset
//               bin_in    - binary value, sampled when in_valid && in_ready
//               in_valid  - conversion request
//               in_ready  - high while idle (request can be accepted)
//               busy      - high while a conversion is running
//               bcd_out   - packed BCD result, digit 0 in [3:0]
//               out_valid - one-cycle pulse when bcd_out has just updated
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seq_conv #(
    parameter int IN_WIDTH = 24,
    parameter int DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_scr_w = IN_WIDTH + c_bcd_w;
    localparam int c_cnt_w = $clog2(IN_WIDTH + 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(IN_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [0:0]         r_state;
    logic [c_scr_w-1:0] r_scratch;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_bcd_w-1:0] r_bcd;
    logic               r_out_valid;

    logic [0:0]         w_state_nxt;
    logic [c_scr_w-1:0] w_scratch_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_bcd_w-1:0] w_bcd_nxt;
    logic               w_out_valid_nxt;

    logic [c_scr_w-1:0] w_adj;
    logic [c_scr_w-1:0] w_shifted;

    // The binary half of the scratch register passes through unchanged;
    // only the BCD nibbles above it receive the add-3 correction.
    assign w_adj[IN_WIDTH-1:0] = r_scratch[IN_WIDTH-1:0];

    // Each BCD nibble is corrected independently; a nibble >= 5 becomes
    // >= 8 so the following shift carries it into the next decimal digit.
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_nibble
            logic [3:0] w_nib;
            assign w_nib = r_scratch[IN_WIDTH + 4*d +: 4];
            assign w_adj[IN_WIDTH + 4*d +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
        end
    endgenerate

    // The top bit is discarded; with legal parameters it is always zero.
    assign w_shifted = {w_adj[c_scr_w-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_scratch   <= w_scratch_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bcd       <= w_bcd_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_scratch_nxt   = r_scratch;
        w_cnt_nxt       = r_cnt;
        w_bcd_nxt       = r_bcd;
        w_out_valid_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_scratch_nxt = {{c_bcd_w{1'b0}}, bin_in};
                    w_cnt_nxt     = c_cnt_init;
                    w_state_nxt   = c_st_shift;
                end
            end
            c_st_shift: begin
                w_scratch_nxt = w_shifted;
                w_cnt_nxt     = r_cnt - c_cnt_one;
                // Last iteration: publish the BCD half of the shifted value.
                if (r_cnt == c_cnt_one) begin
                    w_bcd_nxt       = w_shifted[c_scr_w-1 -: c_bcd_w];
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign in_ready  = (r_state == c_st_idle);
    assign busy      = (r_state == c_st_shift);
    assign bcd_out   = r_bcd;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_seq_conv
// Description : Self-checking bench for bcd_seq_conv. Expected BCD values come
//               from a decimal-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_conv;

    localparam int IN_WIDTH = 24;
    localparam int DIGITS   = 8;

    logic                clk;
    logic                rst;
    logic [IN_WIDTH-1:0] bin_in;
    logic                in_valid;
    logic                in_ready;
    logic                busy;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [IN_WIDTH-1:0] bin;
        logic [4*DIGITS-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    bcd_seq_conv #(
        .IN_WIDTH (IN_WIDTH),
        .DIGITS   (DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion; optionally scribbles on the inputs while busy.
    task automatic convert(input logic [IN_WIDTH-1:0] v, input logic [4*DIGITS-1:0] exp,
                           input bit noise, input string name);
        int lat;
        int bad_busy;
        logic [4*DIGITS-1:0] prev;
        prev = bcd_out;
        chk({name, " ready_before"}, 64'(in_ready), 64'd1);
        bin_in   = v;
        in_valid = 1'b1;
        tick(); // T0
        in_valid = 1'b0;
        lat      = 0;
        bad_busy = 0;
        while (!out_valid && lat < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad_busy++;
            if (bcd_out !== prev) bad_busy++;
            if (noise) begin
                bin_in   = IN_WIDTH'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk({name, " latency"}, 64'(lat), 64'(IN_WIDTH));
        chk({name, " busy_hold"}, 64'(bad_busy), 64'd0);
        chk({name, " bcd"}, 64'(bcd_out), 64'(exp));
        chk({name, " ready_at_done"}, 64'({in_ready, busy}), 64'b10);
        tick();
        chk({name, " pulse_one_cycle"}, 64'({out_valid, busy}), 64'b00);
        chk({name, " bcd_hold"}, 64'(bcd_out), 64'(exp));
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bin_in   = '0;
        in_valid = 1'b0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", 64'({bcd_out, in_ready, busy, out_valid}), 64'({32'h0, 3'b100}));

        // Directed table
        vecs[0] = '{24'd12345678, 32'h1234_5678};
        vecs[1] = '{24'd0,        32'h0000_0000};
        vecs[2] = '{24'hFFFFFF,   32'h1677_7215};
        vecs[3] = '{24'd9,        32'h0000_0009};
        vecs[4] = '{24'd10,       32'h0000_0010};
        vecs[5] = '{24'd99999,    32'h0009_9999};
        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].bin, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Held in_valid: second acceptance at T0+25 samples the new value.
        begin
            int bad;
            bad      = 0;
            bin_in   = 24'd999;
            in_valid = 1'b1;
            tick(); // T0
            for (int i = 1; i <= 49; i++) begin
                tick();
                if (i == 5) bin_in = 24'd1000;
                if (i != 24 && i != 49 && out_valid) bad++;
                if (i == 24) begin
                    chk("hold_first_bcd", 64'({bcd_out, out_valid, in_ready}), 64'({32'h0000_0999, 2'b11}));
                end
                if (i == 25) begin
                    chk("hold_reaccept", 64'({busy, in_ready}), 64'b10);
                    in_valid = 1'b0;
                end
                if (i == 49) begin
                    chk("hold_second_bcd", 64'({bcd_out, out_valid}), 64'({32'h0000_1000, 1'b1}));
                end
            end
            chk("hold_no_stray_pulse", 64'(bad), 64'd0);
            tick();
        end

        // Reset mid-conversion
        convert(24'd42, 32'h0000_0042, 1'b0, "pre_abort");
        begin
            int bad;
            bad      = 0;
            bin_in   = 24'd777;
            in_valid = 1'b1;
            tick(); // T0
            in_valid = 1'b0;
            for (int i = 1; i <= 9; i++) tick();
            rst = 1'b1;
            tick(); // T0+10
            rst = 1'b0;
            chk("abort_state", 64'({bcd_out, out_valid, in_ready, busy}), 64'({32'h0, 3'b010}));
            for (int i = 0; i < 30; i++) begin
                if (out_valid || busy || bcd_out !== 32'h0) bad++;
                tick();
            end
            chk("abort_quiet", 64'(bad), 64'd0);
        end
        convert(24'd5, 32'h0000_0005, 1'b0, "after_abort");

        // Randomized against the reference model, with input noise while busy
        for (int i = 0; i < 25; i++) begin
            logic [IN_WIDTH-1:0] v;
            v = IN_WIDTH'($urandom);
            if (i % 5 == 0) v = IN_WIDTH'($urandom_range(0, 200));
            convert(v, ref_bcd(32'(v)), 1'b1, $sformatf("rnd%0d_%0d", i, v));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_seq_conv.md
Name: bcd_seq_conv

Overview:
- Iterative shift-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly upstream of the seven-segment display driver. It takes the 24-bit binary value the CPU writes to the display MMIO register and produces 8 packed BCD digits, one digit per tube.
- Replaces per-digit combinational divide/modulo with a 24-cycle sequential conversion. The output register holds the last completed result, so the display never shows a partially converted value.

Parameters:
- IN_WIDTH, 24, width of the binary input; also the number of shift iterations.
- DIGITS, 8, number of BCD output digits. Requires 10^DIGITS > 2^IN_WIDTH - 1; the defaults satisfy this (max 16,777,215).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- bin_in  in  IN_WIDTH  binary value to convert
- in_valid  in  1  request; bin_in is sampled when in_valid && in_ready at a rising edge
- in_ready  out  1  high only in IDLE
- busy  out  1  high while in SHIFT
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in [3:0], MSD in [4*DIGITS-1:4*DIGITS-4]; registered
- out_valid  out  1  one-cycle pulse when bcd_out has just been updated

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, bcd_out=0, out_valid=0, busy=0, in_ready=1 in the cycle after the edge.
  - Internal shift register and counter are cleared.
  - Synchronous only; rst has no effect between edges.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, busy=0.
  - On an edge with in_valid=1: scratch := {4*DIGITS zeros, bin_in}, cnt := IN_WIDTH, go to SHIFT.
  - With in_valid=0: stay in IDLE; bcd_out holds its value.
- SHIFT (one iteration per edge):
  - For every BCD nibble of the scratch register ≥ 5, add 3 (per nibble, no carry between nibbles).
  - Then shift the whole scratch left by 1; cnt := cnt - 1.
  - On the edge where cnt goes 1 -> 0: bcd_out := upper 4*DIGITS bits of the post-shift scratch, out_valid := 1 for exactly the next cycle, state := IDLE.
- Latency:
  - Acceptance edge T0; the final shift and the bcd_out update occur at edge T0+IN_WIDTH (24 with defaults).
  - in_ready returns high in the same cycle that out_valid is high. A new request can be accepted at edge T0+IN_WIDTH+1, giving a throughput of one conversion per IN_WIDTH+1 cycles.
- in_valid while busy: ignored; no queuing. bin_in changes during SHIFT do not affect the running conversion.
- bcd_out changes only at the completion edge or at reset, never mid-conversion.
- out_valid is 0 at all other times, including the cycle after an aborted conversion.
- Reset mid-SHIFT: the conversion is aborted, bcd_out is cleared to 0, no out_valid is emitted, and the block is ready in the next cycle.
- Arithmetic: scratch width is IN_WIDTH + 4*DIGITS. The add-3 rule guarantees no nibble exceeds 9 after the shift. With legal parameters no overflow is possible; bits shifted out of the top are discarded.
- No combinational path from any input to any output; all outputs are registers or decode of the state register.

Test Plan:
- rst for 2 cycles, then release -> bcd_out=32'h0000_0000, in_ready=1, busy=0, out_valid=0.
- bin_in=24'd12345678, in_valid for 1 cycle -> busy high for 24 cycles; at edge T0+24 bcd_out=32'h1234_5678 with a single out_valid pulse; in_ready high that same cycle.
- Boundary values:
  - bin_in=0 -> bcd_out=32'h0000_0000 after 24 cycles, out_valid pulsed.
  - bin_in=24'hFFFFFF -> bcd_out=32'h1677_7215.
  - bin_in=24'd9 -> 32'h0000_0009.
  - bin_in=24'd10 -> 32'h0000_0010.
- Hold in_valid=1 continuously:
  - bin_in=24'd999 first, switched to 24'd1000 at T0+5 -> first result 32'h0000_0999.
  - The next acceptance happens at T0+25 and samples 24'd1000; its result is 32'h0000_1000 at T0+49.
- Complete a conversion of 24'd42, then start 24'd777 and assert rst at T0+10 -> bcd_out=0 after the reset edge, no out_valid. A new request of 24'd5 then yields 32'h0000_0005 24 cycles after acceptance.
